// File: rtl/audio_pkg.sv
// Shared audio DMA definitions: default widths, line geometry helpers and
// the frame-control state encoding used by the loader and the writer.
package audio_pkg;

    localparam int DEF_SIZE        = 8;
    localparam int DEF_OUTPUT_SIZE = 512;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } audio_state_t;

    function automatic int samples_per_line(input int size, input int output_size);
        return output_size / size;
    endfunction

    function automatic int lines(input int samples, input int size, input int output_size);
        return (samples * size) / output_size;
    endfunction

endpackage

// File: rtl/audio_line_packer.sv
// Collects SIZE-bit samples into one OUTPUT_SIZE-bit line. line always shows
// the complete line including a sample being accepted this cycle.
module audio_line_packer
    import audio_pkg::*;
#(
    parameter int SIZE = DEF_SIZE,
    parameter int SPL  = DEF_OUTPUT_SIZE / DEF_SIZE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                accept,
    input  logic [SIZE-1:0]     sample,
    input  logic                slot_free,
    output logic                line_complete,
    output logic                pack_full,
    output logic [SIZE*SPL-1:0] line
);

    localparam int CNT_W = $clog2(SPL);

    logic [SIZE*SPL-1:0] pack;
    logic [CNT_W-1:0]    cnt;

    assign line_complete = accept && (cnt == CNT_W'(SPL - 1));

    always_comb begin
        line = pack;
        if (accept) begin
            line[SIZE*int'(cnt) +: SIZE] = sample;
        end
    end

    // A completed line that cannot move to the output slot parks here until it frees.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack      <= '0;
            cnt       <= '0;
            pack_full <= 1'b0;
        end else if (clear) begin
            pack      <= '0;
            cnt       <= '0;
            pack_full <= 1'b0;
        end else begin
            if (accept) begin
                pack[SIZE*int'(cnt) +: SIZE] <= sample;
                cnt <= line_complete ? '0 : cnt + 1'b1;
            end
            if (line_complete && !slot_free) begin
                pack_full <= 1'b1;
            end else if (pack_full && slot_free) begin
                pack_full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/audio_writer.sv
// Packs a frame of processed samples into indexed lines for the DMA write port.
// Handshakes: a transfer happens on a rising edge where valid && ready are both high.
module audio_writer
    import audio_pkg::*;
#(
    parameter int SIZE        = DEF_SIZE,
    parameter int SAMPLES     = 1048576,
    parameter int OUTPUT_SIZE = DEF_OUTPUT_SIZE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   smp_valid,
    output logic                   smp_ready,
    input  logic [SIZE-1:0]        smp_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUTPUT_SIZE-1:0] out_data,
    output logic [$clog2(lines(SAMPLES, SIZE, OUTPUT_SIZE))-1:0] out_index,
    output logic                   busy,
    output logic                   done,
    output audio_state_t           state_dbg
);

    localparam int SPL   = samples_per_line(SIZE, OUTPUT_SIZE);
    localparam int LINES = lines(SAMPLES, SIZE, OUTPUT_SIZE);
    localparam int IDX_W = $clog2(LINES);

    audio_state_t     state, state_next;
    logic [IDX_W-1:0] line_cnt;
    logic             start_frame, accept, slot_free, xfer, last_line;
    logic             line_complete, pack_full;
    logic [OUTPUT_SIZE-1:0] line;

    assign start_frame = (state == IDLE) && start;
    assign accept      = smp_valid && smp_ready;
    assign slot_free   = !out_valid || out_ready;
    assign xfer        = slot_free && (line_complete || pack_full);
    assign last_line   = line_complete && (line_cnt == IDX_W'(LINES - 1));
    assign state_dbg   = state;

    audio_line_packer #(.SIZE(SIZE), .SPL(SPL)) u_packer (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (start_frame),
        .accept        (accept),
        .sample        (smp_data),
        .slot_free     (slot_free),
        .line_complete (line_complete),
        .pack_full     (pack_full),
        .line          (line)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        smp_ready  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                smp_ready = !pack_full;
                busy      = 1'b1;
                if (last_line) state_next = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (out_valid && out_ready && !pack_full) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Line counter saturates on the final line; only a new start clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_cnt <= '0;
        end else if (start_frame) begin
            line_cnt <= '0;
        end else if (xfer && (line_cnt != IDX_W'(LINES - 1))) begin
            line_cnt <= line_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= line;
            out_index <= line_cnt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_audio_writer.sv
// Scoreboard bench for audio_writer on a 256-sample frame (4 lines of 64 bytes).
module tb_audio_writer;
    import audio_pkg::*;

    localparam int SIZE        = 8;
    localparam int OUTPUT_SIZE = 512;
    localparam int SAMPLES     = 256;
    localparam int SPL         = OUTPUT_SIZE / SIZE;
    localparam int LINES       = SAMPLES / SPL;
    localparam int IDX_W       = 2;
    localparam int W           = OUTPUT_SIZE + IDX_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic smp_valid = 1'b0;
    logic [SIZE-1:0] smp_data = '0;
    logic out_ready = 1'b0;
    logic smp_ready, out_valid, busy, done;
    logic [OUTPUT_SIZE-1:0] out_data;
    logic [IDX_W-1:0] out_index;
    audio_state_t state_dbg;

    audio_writer #(.SIZE(SIZE), .SAMPLES(SAMPLES), .OUTPUT_SIZE(OUTPUT_SIZE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .smp_valid (smp_valid),
        .smp_ready (smp_ready),
        .smp_data  (smp_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // clock / reset block
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int rdy_mode = 0;
    bit tp_mode = 1'b0;
    int bp_cnt = 0;
    bit bp_checked = 1'b0;
    int frame_line = 0;
    int n_acc = 0;
    int acc_cyc[SAMPLES];
    int last_out_cyc = 0;
    int done_cnt = 0;
    int exp_done = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: drives the DMA side's ready and checks every presented line
    initial begin
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (out_valid && bp_cnt < 100) begin
                        out_ready = 1'b0;
                        bp_cnt++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'b0;
            endcase
            if (!rst_n) continue;
            if (out_valid) begin
                if (exp_q.size() == 0) check("unexpected_line", 1, 0);
                else check("line", {out_index, out_data}, exp_q[0]);
                if (out_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    if (tp_mode && frame_line < LINES)
                        check("tp_latency", cyc, acc_cyc[frame_line*SPL + SPL - 1] + 1);
                    frame_line++;
                    last_out_cyc = cyc;
                end
            end
            if (done) begin
                done_cnt++;
                check("busy_with_done", busy, 0);
                check("done_latency", cyc, last_out_cyc + 1);
            end
            if (tp_mode && state_dbg == RUN) check("tp_ready", smp_ready, 1);
            if (rdy_mode == 2 && bp_cnt == 100 && !bp_checked) begin
                bp_checked = 1'b1;
                check("bp_accepted", n_acc, 2*SPL);
                check("bp_ready_low", smp_ready, 0);
            end
        end
    end

    // driver: builds the frame, queues its expected lines, then feeds samples
    task automatic run_frame(input bit rand_data, input bit rand_valid, input int stop, input bit inject);
        logic [SIZE-1:0] smp[SAMPLES];
        logic [OUTPUT_SIZE-1:0] ln;
        logic [IDX_W-1:0] idx;
        int i, budget;
        bit injected;
        for (int k = 0; k < SAMPLES; k++)
            smp[k] = rand_data ? SIZE'($urandom_range(0, 255)) : SIZE'(k & 'hFF);
        for (int j = 0; j < LINES; j++) begin
            ln = '0;
            for (int k = 0; k < SPL; k++) ln[SIZE*k +: SIZE] = smp[j*SPL + k];
            idx = IDX_W'(j);
            exp_q.push_back({idx, ln});
        end
        frame_line = 0;
        n_acc = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        i = 0;
        budget = 0;
        injected = 1'b0;
        while (i < stop) begin
            smp_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            smp_data  = smp[i];
            start = inject && (i >= 100) && !injected;
            if (start) injected = 1'b1;
            if (smp_valid && smp_ready) begin
                acc_cyc[i] = cyc;
                i++;
                n_acc = i;
            end
            @(negedge clk);
            budget++;
            if (budget > 4000) begin
                check("feed_timeout", 0, 1);
                break;
            end
        end
        smp_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_done();
        exp_done++;
        for (int t = 0; t < 1000 && done_cnt != exp_done; t++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("done_count", done_cnt, exp_done);
        check("queue_empty", exp_q.size(), 0);
        check("busy_idle", busy, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_smp_ready", smp_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_data", {out_index, out_data}, 0);

        // samples offered while idle are not consumed
        for (int t = 0; t < 10; t++) begin
            smp_valid = 1'b1;
            smp_data = SIZE'($urandom_range(0, 255));
            @(negedge clk);
            check("idle_ready", smp_ready, 0);
            check("idle_out_valid", out_valid, 0);
        end
        smp_valid = 1'b0;

        // byte order and full-rate throughput
        rdy_mode = 0;
        tp_mode = 1'b1;
        run_frame(1'b0, 1'b0, SAMPLES, 1'b0);
        wait_done();
        tp_mode = 1'b0;

        // long backpressure after the first line
        bp_cnt = 0;
        bp_checked = 1'b0;
        rdy_mode = 2;
        run_frame(1'b1, 1'b0, SAMPLES, 1'b0);
        wait_done();
        check("bp_seen", bp_checked, 1);

        // random handshakes with a stray start mid-frame
        rdy_mode = 1;
        run_frame(1'b1, 1'b1, SAMPLES, 1'b1);
        wait_done();

        // reset mid-frame while line 0 is held and line 1 is partial
        rdy_mode = 3;
        run_frame(1'b1, 1'b1, 100, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", {out_index, out_data}, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_smp_ready", smp_ready, 0);
        check("mid_rst_done", done, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rdy_mode = 1;
        repeat (3) @(negedge clk);
        check("no_done_after_rst", done_cnt, exp_done);

        // clean frame after reset restarts at index 0
        run_frame(1'b1, 1'b1, SAMPLES, 1'b0);
        wait_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/audio_writer.md
Name: audio_writer

Overview:
- Inverse of the host-to-accelerator audio loader: takes a stream of processed SIZE-bit samples and packs them into OUTPUT_SIZE-bit lines for the host write-back path.
- Sits between the processing pipeline output and the DMA write port.
- Emits each line with its line index so the DMA can address it.
- One frame of SAMPLES samples per start, then signals done.

Parameters:
- SIZE, 8, bits per sample; must divide OUTPUT_SIZE.
- SAMPLES, 1048576, samples per frame; must be a multiple of SAMPLES_PER_LINE.
- OUTPUT_SIZE, 512, bits per output line.
- Derived, not overridable: SAMPLES_PER_LINE = OUTPUT_SIZE/SIZE (64); LINES = SAMPLES*SIZE/OUTPUT_SIZE; IDX_W = $clog2(LINES).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; begins a frame, accepted only in IDLE.
- smp_valid  in  1  sample available.
- smp_ready  out  1  writer accepts a sample this cycle.
- smp_data  in  SIZE  sample value.
- out_valid  out  1  out_data/out_index valid.
- out_ready  in  1  DMA accepts the line.
- out_data  out  OUTPUT_SIZE  packed line; sample k of the line sits at [SIZE*k +: SIZE].
- out_index  out  IDX_W  line number within the frame, 0..LINES-1.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the last line is accepted.

Behaviour:
- Reset values:
  - All outputs 0.
  - Pack register, sample counter, line counter and held-line register all cleared.
  - State IDLE.
- States:
  - IDLE: start goes to RUN; busy rises the next cycle.
  - RUN: packing samples.
  - DRAIN: all samples accepted; the last line is not yet taken.
  - DONE: one cycle; done=1, then back to IDLE.
- Sample accept:
  - Accept occurs when smp_valid && smp_ready.
  - Sample is written to pack[SIZE*cnt +: SIZE]; cnt increments.
  - smp_ready = (state==RUN) && !pack_full.
- Line completion:
  - Completion is the accept with cnt == SAMPLES_PER_LINE-1.
  - If the out slot is free (!out_valid or out_ready this cycle): the completed line, including the sample just accepted, loads into out_data on the same edge.
    - out_valid=1 next cycle.
    - out_index = line counter; line counter increments.
    - cnt wraps to 0.
    - Sustained throughput is 1 sample/cycle with out_ready tied high.
  - Otherwise: pack_full is set and smp_ready drops. The transfer happens on the first cycle the slot frees, then pack_full clears.
- Output handshake:
  - out_data and out_index stay stable while out_valid && !out_ready.
  - out_valid clears on accept unless a new line loads on the same edge.
- Frame end:
  - On the completion of line LINES-1, state goes to DRAIN. smp_ready=0 for the rest of the frame.
  - DRAIN goes to DONE on the cycle out_valid && out_ready, with no pack pending.
- start outside IDLE is ignored.
- smp_valid outside RUN is ignored; no sample is consumed.
- The line counter, sample counter and pack register clear on start.
  - A stale partial line never appears.
  - out_data upper lanes of a new line come only from new samples.
- Reset mid-frame:
  - Asynchronously returns everything to reset values.
  - A held line is dropped; out_valid falls immediately.
  - done is not pulsed.
- Counter widths: cnt is $clog2(SAMPLES_PER_LINE); the line counter is IDX_W. Both wrap only by explicit clear, never by overflow.

Decomposition:
- audio_pkg holds SIZE/OUTPUT_SIZE defaults, SAMPLES_PER_LINE and LINES functions, and the state enum typedef (IDLE, RUN, DRAIN, DONE). It is shared with the loader.
- One sub-module is natural: audio_line_packer.
  - Contents: pack register, cnt, pack_full.
  - Ports: accept strobe, sample, line_complete, line out.
- The FSM, held-line register and line counter stay in audio_writer.

Test Plan:
- Byte order: SAMPLES=256, SIZE=8, OUTPUT_SIZE=512, sample k=k&0xFF, out_ready=1 -> 4 lines, index 0..3, line0 out_data[7:0]=0x00, [15:8]=0x01, [511:504]=0x3F, line3 [511:504]=0xFF; done 1 cycle after line3 accepted.
- Throughput: smp_valid=1, out_ready=1 -> smp_ready never low in RUN; out_valid rises the cycle after samples 63, 127, 191 and 255 are accepted.
- Backpressure: out_ready=0 for 100 cycles after line0 -> line0 is held stable; line1 packs, then smp_ready=0 with pack_full; on release, line0 then line1 are accepted, in order, with no sample lost.
- Random smp_valid and out_ready (seeded) -> scoreboard matches every line and index exactly; done exactly once; busy deasserts with done.
- start during RUN -> ignored, line counter unaffected; smp_valid in IDLE -> smp_ready=0, nothing emitted.
- rst_n low mid-line1 -> all outputs 0 immediately, no done; a new start gives index 0 with clean data.
